wb_trace_checker: RTL

Consumes the CPU write-back debug trace (`debug_wb_pc`, `debug_wb_rf_wen`, `debug_wb_rf_wnum`, `debug_wb_rf_wdata`, driven from the general register file's write port) and checks it against a golden trace stream. Captured write-back events are buffered in a small FIFO so the golden source may lag. Each buffered event is compared with the next golden record, and the first divergence or overflow is latched for the testbench or debug host. The block sits beside the core in simulation and FPGA bring-up builds and is never in the datapath.

---
 rtl/wb_trace_checker_if.sv | 53 +++++
 rtl/wb_trace_checker.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/wb_trace_checker_if.sv
//------------------------------------------------------------------------------
// Module   : wb_trace_checker_if
// Function : Write-back trace, golden record and result bundle for the checker.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface wb_trace_checker_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [31:0]   debug_wb_pc;
  logic [3:0]    debug_wb_rf_wen;
  logic [4:0]    debug_wb_rf_wnum;
  logic [31:0]   debug_wb_rf_wdata;
  logic          golden_valid;
  logic          golden_ready;
  logic [31:0]   golden_pc;
  logic [4:0]    golden_wnum;
  logic [31:0]   golden_wdata;
  logic          error;
  logic [1:0]    err_code;
  logic [31:0]   err_pc;
  logic [31:0]   err_expected;
  logic [31:0]   err_actual;
  logic [LW-1:0] fifo_level;
`ifdef WB_TRACE_MATCH_COUNT_EN
  logic [31:0]   match_count;
`endif

  modport master (
    output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
    output golden_valid, golden_pc, golden_wnum, golden_wdata,
    input  golden_ready, error, err_code, err_pc, err_expected, err_actual,
`ifdef WB_TRACE_MATCH_COUNT_EN
    input  match_count,
`endif
    input  fifo_level
  );

  modport slave (
    input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
    input  golden_valid, golden_pc, golden_wnum, golden_wdata,
    output golden_ready, error, err_code, err_pc, err_expected, err_actual,
`ifdef WB_TRACE_MATCH_COUNT_EN
    output match_count,
`endif
    output fifo_level
  );
endinterface

`default_nettype wire

// File: rtl/wb_trace_checker.sv
//------------------------------------------------------------------------------
// Module   : wb_trace_checker
// Function : Buffers CPU write-back trace events and compares them with a golden
//            stream; latches the first mismatch or overflow.
//            Optional match counter: define WB_TRACE_MATCH_COUNT_EN.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_trace_checker #(
  parameter int DEPTH = 8
) (
  input  wire               clk,
  input  wire               reset,
  wb_trace_checker_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] C_FULL_LEVEL = LW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } ev_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    ERROR = 1'b1
  } state_t;

  state_t        state_q, state_d;
  ev_t           mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [1:0]    err_code_q, err_code_d;
  logic [31:0]   err_pc_q, err_pc_d;
  logic [31:0]   err_exp_q, err_exp_d;
  logic [31:0]   err_act_q, err_act_d;

  ev_t  w_head;
  logic w_run, w_empty, w_full;
  logic w_push_req, w_push, w_pop, w_overflow;
  logic w_pc_mis, w_lane_mis, w_data_mis, w_mismatch;

  always_comb begin
    w_head     = mem_q[rd_ptr_q];
    w_run      = (state_q == RUN);
    w_empty    = (level_q == '0);
    w_full     = (level_q == C_FULL_LEVEL);
    w_push_req = w_run && (|bus.debug_wb_rf_wen);
    w_pop      = w_run && !w_empty && bus.golden_valid;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    w_push     = w_push_req && (!w_full || w_pop);
    w_overflow = w_push_req && w_full && !w_pop;

    w_lane_mis = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (w_head.wen[b] && (w_head.wdata[8*b +: 8] != bus.golden_wdata[8*b +: 8])) begin
        w_lane_mis = 1'b1;
      end
    end
    w_pc_mis   = (w_head.pc != bus.golden_pc);
    w_data_mis = (w_head.wnum != bus.golden_wnum) || w_lane_mis;
    w_mismatch = w_pop && (w_pc_mis || w_data_mis);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      err_code_q <= 2'd0;
      err_pc_q   <= '0;
      err_exp_q  <= '0;
      err_act_q  <= '0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      err_pc_q   <= err_pc_d;
      err_exp_q  <= err_exp_d;
      err_act_q  <= err_act_d;
    end
  end

  // Overflow takes priority over a same-cycle compare mismatch.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    err_pc_d   = err_pc_q;
    err_exp_d  = err_exp_q;
    err_act_d  = err_act_q;
    case (state_q)
      RUN: begin
        if (w_overflow) begin
          state_d    = ERROR;
          err_code_d = 2'd3;
          err_pc_d   = bus.debug_wb_pc;
          err_exp_d  = '0;
          err_act_d  = bus.debug_wb_rf_wdata;
        end else if (w_mismatch) begin
          state_d    = ERROR;
          err_code_d = w_pc_mis ? 2'd1 : 2'd2;
          err_pc_d   = w_head.pc;
          err_exp_d  = bus.golden_wdata;
          err_act_d  = w_head.wdata;
        end
      end
      default: state_d = ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= '{pc:    bus.debug_wb_pc,
                           wen:   bus.debug_wb_rf_wen,
                           wnum:  bus.debug_wb_rf_wnum,
                           wdata: bus.debug_wb_rf_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

`ifdef WB_TRACE_MATCH_COUNT_EN
  logic [31:0] match_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      match_q <= '0;
    end else if (w_pop && !w_mismatch) begin
      match_q <= match_q + 32'd1;
    end
  end

  assign bus.match_count = match_q;
`endif

  assign bus.golden_ready = w_run && !w_empty;
  assign bus.error        = (state_q == ERROR);
  assign bus.err_code     = err_code_q;
  assign bus.err_pc       = err_pc_q;
  assign bus.err_expected = err_exp_q;
  assign bus.err_actual   = err_act_q;
  assign bus.fifo_level   = level_q;

endmodule

`default_nettype wire
